// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t  : responder FSM states (IDLE, WAIT, RESP)
//   DATA_W_C : data word width, BE_W_C : byte-enable width
//   CNT_W_C  : wait-state counter width (LATENCY up to 15)
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int DATA_W_C = 32;
  localparam int BE_W_C   = DATA_W_C / 8;
  localparam int CNT_W_C  = 4;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x 32, per-byte write enable,
// registered read. Storage and read register have no reset.
//   i_clk   : clock
//   i_we    : write strobe, bytes selected by i_be
//   i_re    : read strobe, o_rdata updates on the next edge, holds otherwise
//   i_addr  : word index
//   i_be    : byte lane enables
//   i_wdata : write data
//   o_rdata : registered read data
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic                i_re,
  input  logic [AW-1:0]       i_addr,
  input  logic [BE_W_C-1:0]   i_be,
  input  logic [DATA_W_C-1:0] i_wdata,
  output logic [DATA_W_C-1:0] o_rdata
);
  logic [DATA_W_C-1:0] r_mem [DEPTH];
  logic [DATA_W_C-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W_C; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory interface. Captures a load/store
// request, waits LATENCY cycles, commits on the edge entering RESP and
// returns a one-cycle MemReady strobe. Stall freezes the pipeline while
// a request is outstanding.
//   Clock, Reset          : clock, async active-high reset
//   MemRead/MemWrite      : request strobes, held until MemReady
//   MemAddr               : byte address (word aligned, < DEPTH words)
//   MemDataIn, ByteEn     : store data and byte lanes
//   MemDataOut            : load data, valid with MemReady, held between responses
//   MemReady              : response strobe
//   Stall                 : request present and not yet answered
//   AddrError             : error flag, qualified by MemReady
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           MemAddr,
  input  logic [DATA_W-1:0]     MemDataIn,
  input  logic [DATA_W/8-1:0]   ByteEn,
  output logic [DATA_W-1:0]     MemDataOut,
  output logic                  MemReady,
  output logic                  Stall,
  output logic                  AddrError
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W_C-1:0] CNT_INIT =
    (LATENCY > 0) ? CNT_W_C'(LATENCY - 1) : '0;

  state_t               r_state;
  logic [CNT_W_C-1:0]   r_cnt;
  logic                 r_rd, r_wr, r_err;
  logic [AW-1:0]        r_idx;
  logic [DATA_W_C-1:0]  r_wdata;
  logic [BE_W_C-1:0]    r_be;
  logic                 r_ready, r_aerr;
  // Forces MemDataOut to zero after reset and after an error response;
  // cleared by a good load so the RAM read register drives the output.
  logic                 r_zero;

  logic                 w_req, w_addr_err, w_commit;
  logic                 w_c_rd, w_c_wr, w_c_err;
  logic [AW-1:0]        w_c_idx;
  logic [DATA_W_C-1:0]  w_c_data, w_ram_q;
  logic [BE_W_C-1:0]    w_c_be;
  logic                 w_ram_we, w_ram_re;

  assign w_req      = MemRead | MemWrite;
  assign w_addr_err = (MemAddr[1:0] != 2'b00)
                    | ({2'b00, MemAddr[31:2]} >= 32'(DEPTH))
                    | (MemRead & MemWrite);

  // Commit edge: IDLE straight to RESP for zero latency, else last WAIT
  // cycle with the request still held. Reset blocks any commit.
  assign w_commit = ~Reset & w_req &
                    (((r_state == IDLE) && (LATENCY == 0)) ||
                     ((r_state == WAIT) && (r_cnt == '0)));

  // In IDLE the request has not been captured yet, so use live inputs.
  always_comb begin
    w_c_rd   = r_rd;
    w_c_wr   = r_wr;
    w_c_err  = r_err;
    w_c_idx  = r_idx;
    w_c_data = r_wdata;
    w_c_be   = r_be;
    if (r_state == IDLE) begin
      w_c_rd   = MemRead;
      w_c_wr   = MemWrite;
      w_c_err  = w_addr_err;
      w_c_idx  = MemAddr[AW+1:2];
      w_c_data = MemDataIn;
      w_c_be   = ByteEn;
    end
  end

  assign w_ram_we = w_commit & w_c_wr & ~w_c_err;
  assign w_ram_re = w_commit & w_c_rd & ~w_c_err;

  mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .i_clk   (Clock),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_c_idx),
    .i_be    (w_c_be),
    .i_wdata (w_c_data),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_ready <= 1'b0;
      r_aerr  <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_ready <= w_commit;
      if (w_commit) begin
        r_aerr <= w_c_err;
        if (w_c_err)     r_zero <= 1'b1;
        else if (w_c_rd) r_zero <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_rd    <= MemRead;
            r_wr    <= MemWrite;
            r_err   <= w_addr_err;
            r_idx   <= MemAddr[AW+1:2];
            r_wdata <= MemDataIn;
            r_be    <= ByteEn;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!w_req)           r_state <= IDLE;  // initiator abort
          else if (r_cnt == '0) r_state <= RESP;
          else                  r_cnt   <= r_cnt - 1'b1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MemReady   = r_ready;
  assign AddrError  = r_aerr;
  assign MemDataOut = r_zero ? '0 : w_ram_q;
  assign Stall      = w_req & ~r_ready;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory interface.
- The MEM stage issues load/store requests (MemRead/MemWrite, MemAddr, MemDataIn, ByteEn).
- This block holds the word-addressed data store, inserts a configurable number of wait states, and returns read data or write completion with a one-cycle MemReady pulse.
- While a request is outstanding it drives Stall back to the pipeline so every PIPE register freezes.

Parameters:
DATA_W, 32, data word width in bits (must be 32; ByteEn is DATA_W/8).
DEPTH, 1024, number of words in the store; legal word index 0..DEPTH-1.
LATENCY, 2, wait cycles between request capture and response (0..15).

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
MemRead  input  1  load request; held stable by the initiator until MemReady.
MemWrite  input  1  store request; held stable by the initiator until MemReady.
MemAddr  input  32  byte address.
MemDataIn  input  32  store data.
ByteEn  input  4  store byte lanes; bit i enables MemDataIn[8i+7:8i].
MemDataOut  output  32  load data, registered; valid while MemReady is high.
MemReady  output  1  one-cycle response strobe.
Stall  output  1  combinational: (MemRead|MemWrite) & ~MemReady.
AddrError  output  1  registered; qualified by MemReady.

Behaviour:
- Clock and reset:
  - One clock, Clock. Reset is asynchronous and active-high.
  - Reset forces state to IDLE, counter to 0, MemDataOut=0, MemReady=0, AddrError=0.
  - Storage array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If MemRead|MemWrite, capture request fields.
  - If LATENCY=0, go to RESP. Otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT:
  - Counter decrements each cycle. At counter=0, go to RESP.
  - If MemRead and MemWrite both drop low (initiator abort), return to IDLE with no commit and no MemReady.
- Commit happens on the edge entering RESP:
  - Store: enabled bytes are written.
  - Load: word read into MemDataOut.
- RESP:
  - MemReady=1 for exactly one cycle, then unconditionally IDLE.
  - A new request is recognised in the following IDLE cycle, giving throughput of one access per LATENCY+2 cycles.
- Request latency: response strobe appears LATENCY+1 cycles after the cycle the request is first presented in IDLE.
- Stall is high in IDLE and WAIT whenever a request is present, and low in RESP, so the pipeline advances on the RESP edge.
- Error conditions:
  - AddrError is set if any of these holds: MemAddr[1:0]!=0; MemAddr[31:2] >= DEPTH; MemRead and MemWrite both high.
  - An error request still runs the full latency and produces MemReady, with AddrError=1, MemDataOut=0, and no write.
- Loads ignore ByteEn and return the full word.
- A store with ByteEn=0 completes normally and leaves memory unchanged.
- Read-after-write: a load following a store to the same word returns the new data.
- MemDataOut holds its last value between responses.
- Reset asserted in WAIT or RESP: the pending store is not committed if the entering-RESP edge has not yet occurred; MemReady drops immediately.

Decomposition:
- Package mem_pkg holds:
  - the state_t enum {IDLE, WAIT, RESP};
  - DATA_W_C=32 and BE_W_C=4;
  - the LATENCY counter width constant (4).
- One sub-module, mem_array: single-port synchronous RAM, DEPTH x 32, with per-byte write enable and registered read.
  - Instantiated once.
  - No reset on storage.

Test Plan:
- Reset, LATENCY=2: store 0xDEADBEEF to 0x10 with ByteEn=4'hF. Stall is high for 3 cycles, then MemReady pulses once with AddrError=0. A following load from 0x10 returns 0xDEADBEEF after 3 stall cycles.
- Byte lanes: store 0x11223344 to 0x20 (ByteEn=F), then store 0xAABBCCDD with ByteEn=4'b0101. A load from 0x20 returns 0x11BB33DD.
- Errors:
  - Load from 0x13 gives MemReady with AddrError=1 and MemDataOut=0.
  - Store to word index DEPTH (0x1000) gives AddrError=1, and memory is unchanged.
  - MemRead and MemWrite both high gives AddrError=1.
- LATENCY=0 build: back-to-back loads to 0x0 and 0x4 produce MemReady every 2nd cycle, with Stall low only in RESP cycles.
- Reset in WAIT: store 0x55 to 0x8, assert Reset one cycle after capture. MemReady never pulses, and a subsequent load from 0x8 returns the pre-reset contents.
- Abort: drop MemRead during WAIT. The FSM returns to IDLE, no MemReady is produced, and the next request is serviced with full latency.
